// File: rtl/hw_registers_pkg.sv
// Purpose: shared constants and helpers for the 7-segment shift-register chain (driver and receiver).
// Latency: n/a (package only).
// Backpressure: n/a.
package hw_registers_pkg;

  // Default chain geometry: 8-bit registers, 6 digit registers.
  localparam int REG_SIZE_DEFAULT     = 8;
  localparam int NUM_DATA_REG_DEFAULT = 6;

  // One-hot control bytes, lowest byte transmitted first. Byte 0x80 selects
  // digit 0 and byte 0x04 selects digit 5.
  localparam logic [47:0] CONTROL_DATA_SEQUENCE_6_DIG = 48'h04_08_10_20_40_80;

  // Control bit that selects digit k. Digit 0 is the MSB of the control byte.
  function automatic int digit_sel_bit(input int k, input int reg_size);
    return reg_size - 1 - k;
  endfunction

endpackage

// File: rtl/hw_registers_receiver_sync.sv
// Purpose: multi-flop synchronizer with a registered level and a rising-edge strobe.
// Latency: level is valid STAGES cycles after the input; rise is high in the cycle the level first reads 1.
// Backpressure: none; the input is sampled on every clock.
//
// Ports:
//   clk, nrst  : system clock and asynchronous active-low reset
//   i_async    : asynchronous input
//   o_level    : synchronized level (last synchronizer flop)
//   o_rise     : one-cycle strobe on a 0->1 transition of o_level
module sig_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  if (STAGES < 2) begin : g_stages_check
    $error("sig_sync_edge: STAGES must be at least 2");
  end

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  // The edge is a compare of two registers, so a consumer that registers on
  // o_rise updates on the clock after the last synchronizer stage.
  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/hw_registers_receiver.sv
// Purpose: reconstructs control and digit storage registers of the 7-segment shift chain from its serial bus.
// Latency: 3 clk from a bus edge to the register update (2 synchronizer flops + edge compare).
// Backpressure: none; bus must respect >=3 clk per SRCLK phase, outputs are strobes.
//
// Ports:
//   clk, nrst          : system clock, asynchronous active-low reset
//   bit_clk            : bus SRCLK (async)
//   bus_nrst           : bus nSRCLR (async, active-low)
//   control_data_ser   : control SER (async)
//   control_reg_clk    : control RCLK (async)
//   digit_data_ser     : digit SER (async)
//   err_clr            : synchronous clear of the sticky error flags
//   ctrl_q             : control storage register
//   digit_data_out     : latched digit bytes, digit k in slice k
//   digit_valid        : one-cycle strobe per latched digit
//   frame_done         : one-cycle strobe once every digit has latched
//   framing_err        : sticky, RCLK after a shift count other than REG_SIZE
//   multi_sel_err      : sticky, one RCLK selected more than one digit
module hw_registers_receiver
  import hw_registers_pkg::*;
#(
  parameter int REG_SIZE     = REG_SIZE_DEFAULT,
  parameter int NUM_DATA_REG = NUM_DATA_REG_DEFAULT
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             bit_clk,
  input  logic                             bus_nrst,
  input  logic                             control_data_ser,
  input  logic                             control_reg_clk,
  input  logic                             digit_data_ser,
  input  logic                             err_clr,
  output logic [REG_SIZE-1:0]              ctrl_q,
  output logic [NUM_DATA_REG*REG_SIZE-1:0] digit_data_out,
  output logic [NUM_DATA_REG-1:0]          digit_valid,
  output logic                             frame_done,
  output logic                             framing_err,
  output logic                             multi_sel_err
);

  if (NUM_DATA_REG < 1 || NUM_DATA_REG > REG_SIZE) begin : g_param_check
    $error("hw_registers_receiver: NUM_DATA_REG must be within 1..REG_SIZE");
  end

  // Counter spans 0..REG_SIZE+1; REG_SIZE+1 is the saturated "too many" value.
  localparam int                CNT_W    = $clog2(REG_SIZE + 2);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(REG_SIZE);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(REG_SIZE + 1);
  localparam logic [NUM_DATA_REG-1:0] SEL_ONE = NUM_DATA_REG'(1);

  // ---------------------------------------------------------------------------
  // Bus synchronizers. All five share the same depth so the SER levels line up
  // with the detected SRCLK edge.
  // ---------------------------------------------------------------------------
  logic w_bclk_rise;
  logic w_bclk_lvl;
  logic w_rclk_rise;
  logic w_rclk_lvl;
  logic w_bus_nrst;
  logic w_ctrl_ser;
  logic w_digit_ser;

  sig_sync_edge #(.STAGES(2)) u_sync_bclk (
    .clk     (clk),
    .nrst    (nrst),
    .i_async (bit_clk),
    .o_level (w_bclk_lvl),
    .o_rise  (w_bclk_rise)
  );

  sig_sync_edge #(.STAGES(2)) u_sync_rclk (
    .clk     (clk),
    .nrst    (nrst),
    .i_async (control_reg_clk),
    .o_level (w_rclk_lvl),
    .o_rise  (w_rclk_rise)
  );

  sig_sync_edge #(.STAGES(2)) u_sync_bus_nrst (
    .clk     (clk),
    .nrst    (nrst),
    .i_async (bus_nrst),
    .o_level (w_bus_nrst),
    .o_rise  ()
  );

  sig_sync_edge #(.STAGES(2)) u_sync_ctrl_ser (
    .clk     (clk),
    .nrst    (nrst),
    .i_async (control_data_ser),
    .o_level (w_ctrl_ser),
    .o_rise  ()
  );

  sig_sync_edge #(.STAGES(2)) u_sync_digit_ser (
    .clk     (clk),
    .nrst    (nrst),
    .i_async (digit_data_ser),
    .o_level (w_digit_ser),
    .o_rise  ()
  );

  // ---------------------------------------------------------------------------
  // Shift registers and bit counter
  // ---------------------------------------------------------------------------
  logic [REG_SIZE-1:0] r_ctrl_shift;
  logic [REG_SIZE-1:0] r_digit_shift;
  logic [CNT_W-1:0]    r_bit_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ctrl_shift  <= '0;
      r_digit_shift <= '0;
      r_bit_cnt     <= '0;
    end else if (!w_bus_nrst) begin
      r_ctrl_shift  <= '0;
      r_digit_shift <= '0;
      r_bit_cnt     <= '0;
    end else if (w_bclk_rise) begin
      r_ctrl_shift  <= {r_ctrl_shift[REG_SIZE-2:0], w_ctrl_ser};
      r_digit_shift <= {r_digit_shift[REG_SIZE-2:0], w_digit_ser};
      // A simultaneous RCLK closes the old byte; this shift is bit 1 of the next.
      if (w_rclk_rise) begin
        r_bit_cnt <= CNT_ONE;
      end else if (r_bit_cnt != CNT_SAT) begin
        r_bit_cnt <= r_bit_cnt + CNT_ONE;
      end
    end else if (w_rclk_rise) begin
      r_bit_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit selection. A digit latches only on a 0->1 of its control bit, so a
  // held selection does not re-latch on every RCLK.
  // ---------------------------------------------------------------------------
  logic [REG_SIZE-1:0]     r_ctrl_q;
  logic [REG_SIZE-1:0]     w_ctrl_rise_bits;
  logic [NUM_DATA_REG-1:0] w_sel;
  logic [NUM_DATA_REG-1:0] w_latch;
  logic                    w_multi;
  logic                    w_framing;

  assign w_ctrl_rise_bits = r_ctrl_shift & ~r_ctrl_q;

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NUM_DATA_REG; k++) begin
      w_sel[k] = w_ctrl_rise_bits[digit_sel_bit(k, REG_SIZE)];
    end
  end

  assign w_latch   = w_rclk_rise ? w_sel : '0;
  // More than one bit set <=> clearing the lowest set bit leaves something.
  assign w_multi   = |(w_latch & (w_latch - SEL_ONE));
  assign w_framing = w_rclk_rise && (r_bit_cnt != CNT_FULL);

  // ---------------------------------------------------------------------------
  // Storage registers. Registers read the pre-shift contents, so a
  // coincident SRCLK/RCLK latches the old byte like the 74HC595.
  // ---------------------------------------------------------------------------
  logic [NUM_DATA_REG*REG_SIZE-1:0] r_digit_q;
  logic [NUM_DATA_REG-1:0]          r_digit_valid;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ctrl_q      <= '0;
      r_digit_q     <= '0;
      r_digit_valid <= '0;
    end else begin
      r_digit_valid <= w_latch;
      if (w_rclk_rise) begin
        r_ctrl_q <= r_ctrl_shift;
      end
      for (int k = 0; k < NUM_DATA_REG; k++) begin
        if (w_latch[k]) begin
          r_digit_q[k*REG_SIZE +: REG_SIZE] <= r_digit_shift;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame tracking
  // ---------------------------------------------------------------------------
  logic [NUM_DATA_REG-1:0] r_seen;
  logic [NUM_DATA_REG-1:0] w_seen_next;
  logic                    w_frame;
  logic                    r_frame_done;

  assign w_seen_next = r_seen | w_latch;
  assign w_frame     = (|w_latch) && (&w_seen_next);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_seen       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_seen       <= w_frame ? '0 : w_seen_next;
      r_frame_done <= w_frame;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags; a new error takes priority over err_clr.
  // ---------------------------------------------------------------------------
  logic r_framing_err;
  logic r_multi_sel_err;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_framing_err   <= 1'b0;
      r_multi_sel_err <= 1'b0;
    end else begin
      if (w_framing) begin
        r_framing_err <= 1'b1;
      end else if (err_clr) begin
        r_framing_err <= 1'b0;
      end
      if (w_multi) begin
        r_multi_sel_err <= 1'b1;
      end else if (err_clr) begin
        r_multi_sel_err <= 1'b0;
      end
    end
  end

  assign ctrl_q         = r_ctrl_q;
  assign digit_data_out = r_digit_q;
  assign digit_valid    = r_digit_valid;
  assign frame_done     = r_frame_done;
  assign framing_err    = r_framing_err;
  assign multi_sel_err  = r_multi_sel_err;

endmodule

// File: tb/tb_hw_registers_receiver.sv
// Purpose: scoreboard bench for hw_registers_receiver driven by directed bus vectors.
// Latency: expected latch events are queued at stimulus time and matched when strobes appear.
// Backpressure: none; the DUT never stalls the bus.
module tb_hw_registers_receiver;
  import hw_registers_pkg::*;

  logic        clk;
  logic        nrst;
  logic        bit_clk;
  logic        bus_nrst;
  logic        control_data_ser;
  logic        control_reg_clk;
  logic        digit_data_ser;
  logic        err_clr;
  logic [7:0]  ctrl_q;
  logic [47:0] digit_data_out;
  logic [5:0]  digit_valid;
  logic        frame_done;
  logic        framing_err;
  logic        multi_sel_err;

  hw_registers_receiver #(.REG_SIZE(8), .NUM_DATA_REG(6)) dut (
    .clk              (clk),
    .nrst             (nrst),
    .bit_clk          (bit_clk),
    .bus_nrst         (bus_nrst),
    .control_data_ser (control_data_ser),
    .control_reg_clk  (control_reg_clk),
    .digit_data_ser   (digit_data_ser),
    .err_clr          (err_clr),
    .ctrl_q           (ctrl_q),
    .digit_data_out   (digit_data_out),
    .digit_valid      (digit_valid),
    .frame_done       (frame_done),
    .framing_err      (framing_err),
    .multi_sel_err    (multi_sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  vld;
    logic [47:0] dat;
    logic        fd;
    logic        fe;
    logic        me;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_events = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [5:0] vld, input logic [47:0] dat,
                          input logic fd, input logic fe, input logic me);
    exp_t e;
    e.vld = vld; e.dat = dat; e.fd = fd; e.fe = fe; e.me = me;
    exp_q.push_back(e);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the low n bits MSB first, 8 clk per bit, SRCLK left low.
  task automatic send_bits(input logic [7:0] c, input logic [7:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      control_data_ser = c[i];
      digit_data_ser   = d[i];
      wait_clk(4);
      bit_clk = 1'b1;
      wait_clk(4);
      bit_clk = 1'b0;
    end
  endtask

  task automatic rclk_pulse();
    control_reg_clk = 1'b1;
    wait_clk(4);
    control_reg_clk = 1'b0;
    wait_clk(4);
  endtask

  task automatic reset_dut();
    nrst = 1'b0;
    wait_clk(2);
    nrst = 1'b1;
    wait_clk(4);
  endtask

  // Monitor: every strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (nrst && (digit_valid != 6'b0 || frame_done)) begin
      n_events++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: got valid=%b frame_done=%b, expected no strobe",
                 digit_valid, frame_done);
      end else begin
        mon_e = exp_q.pop_front();
        chk($sformatf("latch_event_%0d", n_events),
            {7'b0, digit_valid, digit_data_out, frame_done, framing_err, multi_sel_err},
            {7'b0, mon_e.vld, mon_e.dat, mon_e.fd, mon_e.fe, mon_e.me});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  localparam logic [47:0] DIGITS = 48'h3F_06_5B_4F_66_6D;

  initial begin
    logic [47:0] ctrl_seq;
    logic [47:0] dig_seq;
    logic [63:0] m;

    nrst = 1'b0; bit_clk = 1'b0; bus_nrst = 1'b1; control_data_ser = 1'b0;
    control_reg_clk = 1'b0; digit_data_ser = 1'b0; err_clr = 1'b0;
    wait_clk(3);
    chk("reset_ctrl_q", {56'b0, ctrl_q}, 64'h0);
    chk("reset_digit_data", {16'b0, digit_data_out}, 64'h0);
    chk("reset_strobes_flags", {55'b0, digit_valid, frame_done, framing_err, multi_sel_err}, 64'h0);
    nrst = 1'b1;
    wait_clk(4);

    // Full frame: (80,6D) first ... (04,3F) last.
    ctrl_seq = CONTROL_DATA_SEQUENCE_6_DIG;
    dig_seq  = DIGITS;
    for (int i = 0; i < 6; i++) begin
      m = (64'h1 << (8 * (i + 1))) - 64'h1;
      push_exp(6'(1 << i), dig_seq & m[47:0], (i == 5), 1'b0, 1'b0);
      send_bits(ctrl_seq[8*i +: 8], dig_seq[8*i +: 8], 8);
      rclk_pulse();
    end
    chk("frame_ctrl_q", {56'b0, ctrl_q}, 64'h04);

    // Short byte: 7 shifts leave 0x40 in control (digit 1), 0x55 in digit.
    reset_dut();
    push_exp(6'b000010, 48'h0000_0000_5500, 1'b0, 1'b1, 1'b0);
    send_bits(8'h40, 8'h55, 7);
    rclk_pulse();
    chk("short_framing_err", {63'b0, framing_err}, 64'h1);
    err_clr = 1'b1;
    wait_clk(1);
    err_clr = 1'b0;
    wait_clk(1);
    chk("err_clr_framing", {63'b0, framing_err}, 64'h0);

    // Multi-select.
    reset_dut();
    push_exp(6'b000011, 48'h0000_0000_AAAA, 1'b0, 1'b0, 1'b1);
    send_bits(8'hC0, 8'hAA, 8);
    rclk_pulse();
    chk("multi_sel_err", {63'b0, multi_sel_err}, 64'h1);

    // Coincident SRCLK/RCLK: latch pre-shift FF, shift keeps FE (seen via digit 0).
    reset_dut();
    push_exp(6'b000010, 48'h0000_0000_FF00, 1'b0, 1'b0, 1'b0);
    push_exp(6'b000001, 48'h0000_0000_FFFE, 1'b0, 1'b1, 1'b0);
    send_bits(8'h40, 8'hFF, 8);
    control_data_ser = 1'b0;
    digit_data_ser   = 1'b0;
    wait_clk(4);
    bit_clk = 1'b1;
    control_reg_clk = 1'b1;
    wait_clk(4);
    bit_clk = 1'b0;
    control_reg_clk = 1'b0;
    wait_clk(4);
    rclk_pulse();
    chk("simul_ctrl_q", {56'b0, ctrl_q}, 64'h80);

    // bus_nrst after 4 bits discards them and restarts the count.
    reset_dut();
    push_exp(6'b000001, 48'h0000_0000_0081, 1'b0, 1'b0, 1'b0);
    send_bits(8'h0F, 8'h0F, 4);
    bus_nrst = 1'b0;
    wait_clk(6);
    bus_nrst = 1'b1;
    wait_clk(6);
    send_bits(8'h80, 8'h81, 8);
    rclk_pulse();
    chk("bus_nrst_ctrl_q", {56'b0, ctrl_q}, 64'h80);

    // nrst mid-byte clears outputs without a clock edge.
    send_bits(8'hFF, 8'hFF, 4);
    #1;
    nrst = 1'b0;
    #1;
    chk("async_rst_ctrl_q", {56'b0, ctrl_q}, 64'h0);
    chk("async_rst_digit_data", {16'b0, digit_data_out}, 64'h0);
    chk("async_rst_strobes_flags", {55'b0, digit_valid, frame_done, framing_err, multi_sel_err}, 64'h0);
    @(negedge clk);
    nrst = 1'b1;
    wait_clk(4);
    push_exp(6'b000100, 48'h0000_004F_0000, 1'b0, 1'b0, 1'b0);
    send_bits(8'h20, 8'h4F, 8);
    rclk_pulse();

    wait_clk(10);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
